// File: rtl/timer_bank.sv
// timer_bank -- bank of NCH independent threshold timers.
//
// Each channel counts enabled cycles up to a live threshold. A one-shot channel
// stops in DONE with a sticky finished flag. A periodic channel reloads to zero
// and keeps running. Every threshold hit produces a one-cycle tick.
//
// Optional feature macro: TIMER_BANK_PRESCALE_EN
//   When it is defined, the i_prescale port and a shared divider are added.
//   The channels then count once per (i_prescale+1) cycles with i_en high.
//
// Ports
//   i_clk        clock; all state updates on posedge
//   i_reset_n    asynchronous active-low reset
//   i_en         global count enable
//   i_start      per-channel start/restart strobe (wins over i_stop)
//   i_stop       per-channel stop strobe
//   i_periodic   per-channel mode: 1 = auto-reload, 0 = one-shot
//   i_threshold  per-channel threshold, channel i at [i]; compared live
//   i_prescale   divide ratio minus 1 (TIMER_BANK_PRESCALE_EN only)
//   o_count      per-channel counter value
//   o_busy       channel is running
//   o_finished   sticky one-shot completion flag
//   o_tick       one-cycle pulse on each threshold hit
//   o_any_tick   OR of o_tick

module timer_bank_ch #(
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cnt_en,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_periodic,
  input  logic [WIDTH-1:0] i_threshold,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_finished,
  output logic             o_tick
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_busy;
  logic             r_finished;
  logic             r_tick;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      // Strobes take priority over a hit in the same cycle, so no tick is produced.
      if (i_start) begin
        r_state    <= S_RUN;
        r_busy     <= 1'b1;
        r_count    <= '0;
        r_finished <= 1'b0;
      end else if (i_stop) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_finished <= 1'b0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (i_cnt_en) begin
              // >= lets a lowered threshold fire at once. The count stops at
              // the threshold, so it never wraps even with an all-ones threshold.
              if (r_count >= i_threshold) begin
                r_tick <= 1'b1;
                if (i_periodic) begin
                  r_count <= '0;
                end else begin
                  r_state    <= S_DONE;
                  r_busy     <= 1'b0;
                  r_finished <= 1'b1;
                end
              end else begin
                r_count <= r_count + 1'b1;
              end
            end
          end
          default: ; // IDLE and DONE hold until a strobe
        endcase
      end
    end
  end

  assign o_count    = r_count;
  assign o_busy     = r_busy;
  assign o_finished = r_finished;
  assign o_tick     = r_tick;
endmodule

module timer_bank #(
  parameter int WIDTH = 9,
  parameter int NCH   = 4,
  parameter int PSW   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_en,
  input  logic [NCH-1:0]             i_start,
  input  logic [NCH-1:0]             i_stop,
  input  logic [NCH-1:0]             i_periodic,
  input  logic [NCH-1:0][WIDTH-1:0]  i_threshold,
`ifdef TIMER_BANK_PRESCALE_EN
  input  logic [PSW-1:0]             i_prescale,
`endif
  output logic [NCH-1:0][WIDTH-1:0]  o_count,
  output logic [NCH-1:0]             o_busy,
  output logic [NCH-1:0]             o_finished,
  output logic [NCH-1:0]             o_tick,
  output logic                       o_any_tick
);
  if (WIDTH < 1 || NCH < 1 || PSW < 1) begin : g_bad_param
    $error("timer_bank: WIDTH, NCH and PSW must all be >= 1");
  end

  logic w_cnt_en;

`ifdef TIMER_BANK_PRESCALE_EN
  // The divider is shared by all channels and free-running on i_en. Channel
  // strobes do not reset it, so phase relative to a start is not fixed.
  logic [PSW-1:0] r_pre_cnt;
  logic           w_pre_hit;

  assign w_pre_hit = (r_pre_cnt == i_prescale);
  assign w_cnt_en  = i_en & w_pre_hit;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  r_pre_cnt <= '0;
    else if (i_en)   r_pre_cnt <= w_pre_hit ? '0 : r_pre_cnt + 1'b1;
  end
`else
  assign w_cnt_en = i_en;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    timer_bank_ch #(.WIDTH(WIDTH)) u_ch (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_cnt_en    (w_cnt_en),
      .i_start     (i_start[g]),
      .i_stop      (i_stop[g]),
      .i_periodic  (i_periodic[g]),
      .i_threshold (i_threshold[g]),
      .o_count     (o_count[g]),
      .o_busy      (o_busy[g]),
      .o_finished  (o_finished[g]),
      .o_tick      (o_tick[g])
    );
  end

  assign o_any_tick = |o_tick;
endmodule
